// File: rtl/decoder_pkg.sv
// Shared widths and types for the registered one-hot line decoder.
package decoder_pkg;

  localparam int DEC_IN_W  = 4;
  localparam int DEC_OUT_W = 16;

  typedef logic [DEC_IN_W-1:0]  dec_sel_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decode, gated by an enable.
module onehot_decode
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W
) (
  input  logic [IN_W-1:0]      sel,
  input  logic                 en,
  output logic [(2**IN_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < 2**IN_W; k++) begin
      onehot[k] = en && (sel == IN_W'(k));
    end
  end

endmodule

// File: rtl/decoder_reg.sv
// Registered one-hot decoder: async-reset output register with optional
// active-low output polarity around onehot_decode.
module decoder_reg
  import decoder_pkg::*;
#(
  parameter int IN_W       = DEC_IN_W,
  parameter int OUT_W      = 2**IN_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  ip,
  input  logic             en,
  output logic [OUT_W-1:0] op
);

  // Idle value doubles as the reset value, so reset and en=0 look identical.
  localparam logic [OUT_W-1:0] IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  generate
    if (OUT_W != 2**IN_W) begin : g_width_chk
      $error("decoder_reg: OUT_W (%0d) must equal 2**IN_W (%0d)", OUT_W, 2**IN_W);
    end
  endgenerate

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] op_d;
  logic [OUT_W-1:0] op_q;

  onehot_decode #(
    .IN_W(IN_W)
  ) u_onehot_decode (
    .sel   (ip),
    .en    (en),
    .onehot(onehot)
  );

  always_comb begin
    op_d = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= IDLE;
    end else begin
      op_q <= op_d;
    end
  end

  assign op = op_q;

endmodule

// File: tb/tb_decoder_reg.sv
// Randomized self-checking bench for decoder_reg (active-high and active-low instances).
module tb_decoder_reg;
  import decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  dec_sel_t    ip  = '0;
  dec_onehot_t op0;
  dec_onehot_t op1;

  int pass_cnt = 0;
  int total    = 0;
  bit checking = 1'b0;

  dec_onehot_t model = '0;
  bit          model_en = 1'b0;

  always #5 clk = ~clk;

  decoder_reg #(.IN_W(4), .OUT_W(16), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst(rst), .ip(ip), .en(en), .op(op0)
  );

  decoder_reg #(.IN_W(4), .OUT_W(16), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst(rst), .ip(ip), .en(en), .op(op1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
  endtask

  // Reference: output is the word with bit ip set when enabled, idle otherwise.
  always @(posedge clk) begin
    if (!rst) begin
      model    = en ? (16'h0001 << ip) : 16'h0000;
      model_en = en;
    end
  end

  always @(posedge rst) begin
    model    = 16'h0000;
    model_en = 1'b0;
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_hi", op0, model);
      check("model_lo", op1, ~model);
      check("popcount", 16'($countones(op0)), model_en ? 16'd1 : 16'd0);
    end
  end

  task automatic drive(input logic [3:0] c, input logic e);
    @(negedge clk);
    ip = c;
    en = e;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: operate with en=1, ip=5, then assert rst mid-cycle.
    drive(4'd5, 1'b1);
    after_edge();
    check("pre_reset_ip5", op0, 16'h0020);
    checking = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_async_hi", op0, 16'h0000);
    check("reset_async_lo", op1, 16'hFFFF);
    repeat (3) begin
      after_edge();
      check("reset_hold_hi", op0, 16'h0000);
      check("reset_hold_lo", op1, 16'hFFFF);
    end
    @(negedge clk);
    rst = 1'b0;

    // Sweep all codes.
    for (int k = 0; k < 16; k++) begin
      drive(4'(k), 1'b1);
      after_edge();
      if (k == 0)  check("sweep_ip0", op0, 16'h0001);
      if (k == 9)  check("sweep_ip9", op0, 16'h0200);
      if (k == 15) check("sweep_ip15", op0, 16'h8000);
    end

    // Enable gating.
    drive(4'd7, 1'b0);
    after_edge();
    check("en_off_ip7", op0, 16'h0000);
    drive(4'd7, 1'b1);
    after_edge();
    check("en_on_ip7", op0, 16'h0080);

    // Latency: input change between edges must not reach op.
    drive(4'd3, 1'b1);
    after_edge();
    check("lat_ip3", op0, 16'h0008);
    #2 ip = 4'd12;
    #1;
    check("lat_hold", op0, 16'h0008);
    after_edge();
    check("lat_ip12", op0, 16'h1000);

    // Back-to-back toggling 0/15.
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 0) ? 4'd0 : 4'd15, 1'b1);
      after_edge();
      check("toggle", op0, (i % 2 == 0) ? 16'h0001 : 16'h8000);
    end

    // Partial-cycle reset pulse, then recovery decodes the current ip.
    drive(4'd15, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("pulse_async", op0, 16'h0000);
    #1 rst = 1'b0;
    after_edge();
    check("pulse_recover", op0, 16'h8000);

    // Active-low instance literals.
    drive(4'd2, 1'b1);
    after_edge();
    check("al_ip2", op1, 16'hFFFB);
    drive(4'd2, 1'b0);
    after_edge();
    check("al_en0", op1, 16'hFFFF);
    drive(4'd2, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("al_rst", op1, 16'hFFFF);
    #1 rst = 1'b0;

    // Randomized traffic with occasional partial-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 19) == 0) begin
        #1 rst = 1'b1;
        #1;
        check("rand_rst_hi", op0, 16'h0000);
        check("rand_rst_lo", op1, 16'hFFFF);
        #($urandom_range(1, 2)) rst = 1'b0;
      end
    end

    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
